// File: rtl/input_conditioner.sv
// Input conditioner: 2-flop sync, per-channel debounce, edge pulses, toggle mode, lowest-index select.
// Optional auto-repeat of rise pulses on held non-toggle channels: define INCOND_REPEAT_EN.
module input_conditioner #(
   parameter int              N_CH            = 8,
   parameter int              DEBOUNCE_CYCLES = 1000000,
   parameter logic [N_CH-1:0] TOGGLE_MASK     = {N_CH{1'b0}},
   parameter int              REPEAT_DELAY    = 50000000,
   parameter int              REPEAT_PERIOD   = 10000000,
   localparam int             SEL_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [N_CH-1:0]  raw_in,
   output logic [N_CH-1:0]  level_out,
   output logic [N_CH-1:0]  rise_pulse,
   output logic [N_CH-1:0]  fall_pulse,
   output logic [N_CH-1:0]  state_out,
   output logic             sel_valid,
   output logic [SEL_W-1:0] sel_idx
);

   localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0]  sync_p0;
   logic [N_CH-1:0]  sync_p1;
   logic [N_CH-1:0]  stable;
   logic [N_CH-1:0]  tog;
   logic [N_CH-1:0]  rise_q;
   logic [N_CH-1:0]  fall_q;
   logic [N_CH-1:0]  accept;
   logic [N_CH-1:0]  rep_pulse;
   logic [CNT_W-1:0] cnt [N_CH];
   logic [SEL_W-1:0] sel_nxt;
   logic             sel_vld_nxt;

   // Stage p0/p1: two-flop synchroniser
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw_in;
         sync_p1 <= sync_p0;
      end
   end

   // A channel is accepted when it has disagreed with stable for the full window
   always_comb begin
      accept = '0;
      for (int i = 0; i < N_CH; i++) begin
         accept[i] = (sync_p1[i] != stable[i]) && (cnt[i] == CNT_MAX);
      end
   end

   // Debounce counters, stable level, toggle latch and edge pulses
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         stable <= '0;
         tog    <= '0;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (sync_p1[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stable[i] <= sync_p1[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         rise_q <= (accept & sync_p1) | rep_pulse;
         fall_q <= accept & ~sync_p1;
         tog    <= tog ^ (accept & sync_p1 & TOGGLE_MASK);
      end
   end

`ifdef INCOND_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W  = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

   logic [HOLD_W-1:0] hold [N_CH];
   logic [N_CH-1:0]   rep_armed;

   // First repeat waits REPEAT_DELAY after the accepted rise, later ones REPEAT_PERIOD
   always_comb begin
      rep_pulse = '0;
      for (int i = 0; i < N_CH; i++) begin
         rep_pulse[i] = !TOGGLE_MASK[i] && stable[i] && !accept[i] &&
                        (rep_armed[i] ? (hold[i] == PERIOD_LAST) : (hold[i] == DELAY_LAST));
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rep_armed <= '0;
         for (int i = 0; i < N_CH; i++) begin
            hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!stable[i] || accept[i] || TOGGLE_MASK[i]) begin
               hold[i]      <= '0;
               rep_armed[i] <= 1'b0;
            end else if (rep_pulse[i]) begin
               hold[i]      <= '0;
               rep_armed[i] <= 1'b1;
            end else begin
               hold[i] <= hold[i] + 1'b1;
            end
         end
      end
   end
`else
   localparam int rep_cfg_unused = REPEAT_DELAY ^ REPEAT_PERIOD;
   assign rep_pulse = '0;
`endif

   assign level_out  = stable;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign state_out  = (tog & TOGGLE_MASK) | (stable & ~TOGGLE_MASK);

   // Lowest set index wins; scanning downward leaves the lowest one last
   always_comb begin
      sel_nxt     = '0;
      sel_vld_nxt = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (state_out[i]) begin
            sel_nxt     = SEL_W'(i);
            sel_vld_nxt = 1'b1;
         end
      end
   end

   // Stage p2: registered priority select
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sel_idx   <= '0;
         sel_valid <= 1'b0;
      end else begin
         sel_idx   <= sel_nxt;
         sel_valid <= sel_vld_nxt;
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed steps plus random toggling against a behavioural model.
module tb_input_conditioner;

   localparam int         N  = 4;
   localparam int         DC = 4;
   localparam logic [3:0] TM = 4'b1000;
   localparam int         RD = 10;
   localparam int         RP = 3;
`ifdef INCOND_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr_n = 1'b1;
   logic [3:0] raw_in = '0;
   logic [3:0] level_out, rise_pulse, fall_pulse, state_out;
   logic       sel_valid;
   logic [1:0] sel_idx;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // model state
   logic [3:0] m_s1, m_s2, m_prev, m_stable, m_tog, m_rise, m_fall;
   logic [1:0] m_sel;
   logic       m_vld;
   int         m_age  [4];
   int         m_held [4];

   input_conditioner #(
      .N_CH(N), .DEBOUNCE_CYCLES(DC), .TOGGLE_MASK(TM),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .clr_n(clr_n), .raw_in(raw_in),
      .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .state_out(state_out), .sel_valid(sel_valid), .sel_idx(sel_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] m_state();
      return (m_tog & TM) | (m_stable & ~TM);
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_stable = '0; m_tog = '0;
      m_rise = '0; m_fall = '0; m_sel = '0; m_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_age[i]  = 0;
         m_held[i] = -1;
      end
   endtask

   // An input is accepted once its synchronised value has differed from the
   // accepted level for DC consecutive samples.
   task automatic model_edge();
      logic [3:0] st, x;
      st = m_state();
      m_vld = 1'b0;
      m_sel = '0;
      for (int i = 3; i >= 0; i--) begin
         if (st[i]) begin
            m_vld = 1'b1;
            m_sel = 2'(i);
         end
      end
      x = m_s2;
      m_s2 = m_s1;
      m_s1 = raw_in;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < 4; i++) begin
         if (x[i] == m_prev[i]) m_age[i]++;
         else m_age[i] = 1;
         m_prev[i] = x[i];
         if (x[i] != m_stable[i] && m_age[i] >= DC) begin
            m_stable[i] = x[i];
            if (x[i]) begin
               m_rise[i] = 1'b1;
               if (TM[i]) m_tog[i] = ~m_tog[i];
               m_held[i] = 0;
            end else begin
               m_fall[i] = 1'b1;
               m_held[i] = -1;
            end
         end else if (m_held[i] >= 0) begin
            m_held[i]++;
            if (REP_ON && !TM[i] &&
                (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0)))
               m_rise[i] = 1'b1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_level"}, level_out, m_stable);
      chk({tag, "_rise"},  rise_pulse, m_rise);
      chk({tag, "_fall"},  fall_pulse, m_fall);
      chk({tag, "_state"}, state_out, m_state());
      chk({tag, "_selv"},  {3'b000, sel_valid}, {3'b000, m_vld});
      chk({tag, "_seli"},  {2'b00, sel_idx}, {2'b00, m_sel});
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         if (!clr_n) model_reset();
         else model_edge();
         cyc++;
         #1;
         check_all($sformatf("cyc%0d", cyc));
      end
   endtask

   task automatic async_reset(input int hold_edges);
      clr_n = 1'b0;
      #1;
      model_reset();
      check_all($sformatf("rst%0d", cyc));
      chk("rst_level", level_out, 4'b0000);
      chk("rst_state", state_out, 4'b0000);
      chk("rst_selv", {3'b000, sel_valid}, 4'b0000);
      step(hold_edges);
      clr_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      async_reset(3);

      // clean press on channel 0
      raw_in = 4'b0001;
      step(5);
      chk("press_early", level_out, 4'b0000);
      step(1);
      chk("press_level", level_out, 4'b0001);
      chk("press_rise", rise_pulse, 4'b0001);
      chk("press_sel_late", {3'b000, sel_valid}, 4'b0000);
      step(1);
      chk("press_rise_once", rise_pulse, 4'b0000);
      chk("press_selv", {3'b000, sel_valid}, 4'b0001);
      chk("press_seli", {2'b00, sel_idx}, 4'b0000);
      step(3);
      raw_in = 4'b0000;
      step(5);
      chk("release_early", fall_pulse, 4'b0000);
      step(1);
      chk("release_fall", fall_pulse, 4'b0001);
      step(4);

      // bounce on channel 1
      raw_in[1] = 1'b1; step(3);
      raw_in[1] = 1'b0; step(1);
      raw_in[1] = 1'b1; step(5);
      chk("bounce_early", {3'b000, level_out[1]}, 4'b0000);
      step(1);
      chk("bounce_level", {3'b000, level_out[1]}, 4'b0001);
      step(2);

      // toggle on channel 3
      raw_in[3] = 1'b1; step(6);
      chk("tog_first", {3'b000, state_out[3]}, 4'b0001);
      step(4);
      raw_in[3] = 1'b0; step(8);
      chk("tog_hold", {3'b000, state_out[3]}, 4'b0001);
      chk("tog_lvl", {3'b000, level_out[3]}, 4'b0000);
      raw_in[3] = 1'b1; step(6);
      chk("tog_second", {3'b000, state_out[3]}, 4'b0000);
      step(3);

      // priority select
      raw_in = 4'b0110; step(7);
      chk("prio_state", state_out, 4'b0110);
      chk("prio_seli", {2'b00, sel_idx}, 4'b0001);
      chk("prio_selv", {3'b000, sel_valid}, 4'b0001);
      raw_in = 4'b0000; step(7);
      chk("clear_seli", {2'b00, sel_idx}, 4'b0000);
      chk("clear_selv", {3'b000, sel_valid}, 4'b0000);

      // reset while channel 2 is mid-count
      raw_in = 4'b0100; step(4);
      async_reset(2);
      step(5);
      chk("rst_restart_early", {3'b000, level_out[2]}, 4'b0000);
      step(1);
      chk("rst_restart_level", {3'b000, level_out[2]}, 4'b0001);
      raw_in = 4'b0000; step(8);

      // long hold: auto-repeat on channel 0, single toggle on channel 3
      raw_in = 4'b1001; step(6);
      chk("hold_rise", rise_pulse, 4'b1001);
      step(9);
      step(1);
      chk("hold_repeat", {3'b000, rise_pulse[0]}, {3'b000, REP_ON});
      chk("hold_no_tog_rep", {3'b000, rise_pulse[3]}, 4'b0000);
      step(10);
      raw_in = 4'b0000; step(8);

      // random toggling with occasional resets
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 9) == 0) raw_in[i] = ~raw_in[i];
         end
         if ($urandom_range(0, 299) == 0) async_reset(1);
         else step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised front end for all human-operated inputs (push buttons and slide switches) of the paint design. Every raw input gets a 2-flop synchroniser, a per-channel debounce counter, edge pulses, an optional per-channel toggle (latch) mode, and a registered lowest-index priority select. It sits between the board pins and the colour/tool/size selection logic, and replaces the per-pin debouncer and switch instances with a single block.

## Interface
- `N_CH`, 8: number of input channels (1..32).
- `DEBOUNCE_CYCLES`, 1000000: cycles an input must hold a new value before it is accepted (10 ms at 100 MHz); must be ≥2.
- `TOGGLE_MASK`, {N_CH{1'b0}}: bit i=1 puts channel i in toggle mode.
- `REPEAT_DELAY`, 50000000: cycles of hold before auto-repeat starts (used only with `INCOND_REPEAT_EN`).
- `REPEAT_PERIOD`, 10000000: cycles between repeat pulses (used only with `INCOND_REPEAT_EN`).
- `clk`  in  1  100 MHz system clock.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `raw_in`  in  N_CH  unsynchronised pin levels.
- `level_out`  out  N_CH  debounced level per channel.
- `rise_pulse`  out  N_CH  one-cycle pulse on an accepted 0→1 (plus repeats).
- `fall_pulse`  out  N_CH  one-cycle pulse on an accepted 1→0.
- `state_out`  out  N_CH  toggle-mode channels: latched state; other channels: equal to `level_out`.
- `sel_valid`  out  1  at least one `state_out` bit is set.
- `sel_idx`  out  max(1,$clog2(N_CH))  index of the lowest set `state_out` bit.

## Operation
- Sync: `s1 <= raw_in`; `s2 <= s1`, per channel.
- Debounce, per channel: `stable` register plus `cnt` sized to hold DEBOUNCE_CYCLES-1.
  - `s2 == stable`: cnt ← 0.
  - `s2 != stable` and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - `s2 != stable` and cnt == DEBOUNCE_CYCLES-1: stable ← s2 and cnt ← 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count from 0.
- `level_out` = stable.
- `rise_pulse[i]` / `fall_pulse[i]` are registered and assert in the same cycle `stable` flips; they are high for exactly 1 cycle.
- Toggle channels:
  - `tog[i]` flips on each accepted rise; accepted falls are ignored.
  - `state_out[i]` = tog[i].
- Non-toggle channels: `state_out[i]` = `level_out[i]`.
- Priority select is registered from `state_out`:
  - `sel_idx` = lowest i with `state_out[i]`=1; `sel_valid`=1.
  - No bit set: `sel_idx`=0 and `sel_valid`=0.
- Reset values: all sync flops, stable, cnt, tog and pulses are 0; all outputs are 0.
- Reset asserted mid-count discards the count. After release, the input must again hold for the full DEBOUNCE_CYCLES.

## Timing
- Let `raw_in[i]` change before edge k and stay constant.
  - `s2` updates at edge k+1.
  - `stable` and `level_out` update at edge k+1+DEBOUNCE_CYCLES; the pulse asserts at the same edge.
  - `state_out` updates at that same edge (it is combinational from stable/tog).
  - `sel_idx` and `sel_valid` update one edge later (k+2+DEBOUNCE_CYCLES).
- Channels are fully independent. Simultaneous acceptance on several channels gives simultaneous pulses.
- The select resolves by lowest index.
- No back-to-back edges are possible on one channel within DEBOUNCE_CYCLES+1 cycles.

## Configuration
- `INCOND_REPEAT_EN` defined:
  - Each non-toggle channel gets a hold counter, cleared on any accepted edge or while level=0.
  - After the hold counter reaches REPEAT_DELAY cycles past the accepted rise, `rise_pulse[i]` re-asserts for 1 cycle.
  - It then re-asserts every REPEAT_PERIOD cycles while level stays 1.
  - Toggle channels never repeat.
  - Reset clears all hold counters.
- `INCOND_REPEAT_EN` undefined:
  - No hold counters are synthesised; REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - `rise_pulse` fires only on accepted edges.

## Test plan
Bench parameters: N_CH=4, DEBOUNCE_CYCLES=4, TOGGLE_MASK=4'b1000, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: raw_in[0] 0→1 before edge 0 and held → level_out[0]=1 and rise_pulse[0]=1 for one cycle after edge 5; sel_idx=0 and sel_valid=1 after edge 6. Release → fall_pulse[0] after the same latency.
- Bounce: raw_in[1] high 3 cycles, low 1 cycle, then high and held → the glitch produces no output; level_out[1] rises 5 edges after the final rising transition.
- Toggle: two accepted presses on channel 3 → state_out[3] goes 0→1 on the first, 1→0 on the second, and holds between them regardless of level_out[3].
- Priority: state_out = 4'b0110 → sel_idx=1, sel_valid=1; all channels clear → sel_idx=0, sel_valid=0.
- Reset mid-count: clr_n pulsed low while cnt[2]=2 with raw_in[2] held high → all outputs 0 immediately; level_out[2] rises 5 edges after clr_n release (sync restarts).
- Repeat (INCOND_REPEAT_EN): hold channel 0 → rise_pulse[0] at the accepted edge T, then T+10, T+13, T+16…; channel 3 held shows a single toggle and no repeats. Without the macro: only the pulse at T.
